instruction_fetch_buffer: RTL and testbench

Decoupled fetch front-end for the RV32I core. It issues pipelined requests to an instruction memory port with a request/grant plus in-order response protocol, and buffers returned words with their PCs in a small FIFO. It presents one instruction per cycle to decode through a valid/ready handshake. On a redirect from the PC controller (jump, branch or trap target), it flushes and restarts the stream.

---
 rtl/instruction_fetch_buffer.sv | 193 +++++++++++++++++++
 tb/tb_instruction_fetch_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_buffer.sv
// Decoupled instruction fetch front-end.
// Issues pipelined word requests to the instruction memory (req/gnt with
// in-order responses). Returned words are buffered with their PCs in a FIFO
// and handed to decode one per cycle over valid/ready. A redirect flushes the
// FIFO and restarts fetch. Responses that were already in flight at the
// redirect are counted and dropped as they come back.
// Optional build macro FETCH_FAULT_EN adds a per-entry fetch fault bit
// (imem_err in, if_fault out) and stops fetching after a faulted word.
module instruction_fetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_FAULT_EN
  input  logic        imem_err,
  output logic        if_fault,
`endif
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  input  logic        if_ready
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   last_pc_q;

  logic [31:0]   fifo_pc_q  [DEPTH];
  logic [31:0]   fifo_ins_q [DEPTH];

  logic          grant;
  logic          resp_live;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic          fault_hold;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_base;

  // Low two bits of the redirect target are meaningless for word fetch.
  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

  assign fifo_nonempty = (count_q != '0);
  assign occupancy     = {1'b0, count_q} + {1'b0, outst_q};

  // Credit rule: a request is only issued if its response is guaranteed a
  // FIFO slot, so the memory side never sees backpressure.
  assign imem_req  = reset & ~redirect & ~fault_hold
                   & (outst_q < CW'(MAX_OUTSTANDING))
                   & (occupancy < (CW + 1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign grant     = imem_req & imem_gnt;
  assign resp_live = imem_rvalid & (discard_q == '0);
  assign push      = resp_live & ~redirect & ~fault_hold;
  assign pop       = fifo_nonempty & if_ready;

  assign if_valid       = fifo_nonempty;
  assign if_pc          = fifo_nonempty ? fifo_pc_q[rd_ptr_q] : last_pc_q;
  assign if_instruction = fifo_nonempty ? fifo_ins_q[rd_ptr_q] : NOP;

`ifdef FETCH_FAULT_EN
  logic fault_hold_q;
  logic fifo_flt_q [DEPTH];

  assign fault_hold = fault_hold_q;
  assign if_fault   = fifo_nonempty & fifo_flt_q[rd_ptr_q];

  // Stop fetching once a faulted word is buffered; the trap redirect resumes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_hold_q <= 1'b0;
    end else if (redirect) begin
      fault_hold_q <= 1'b0;
    end else if (push & imem_err) begin
      fault_hold_q <= 1'b1;
    end
  end

  // Fault bit storage alongside each buffered word.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_flt_q[wr_ptr_q] <= imem_err;
    end
  end
`else
  assign fault_hold = 1'b0;
`endif

  // Next-state for fetch/response PCs, FIFO pointers and in-flight counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (grant & ~imem_rvalid) begin
      outst_d = outst_q + CW'(1);
    end else if (~grant & imem_rvalid) begin
      outst_d = outst_q - CW'(1);
    end

    if (imem_rvalid & (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end

    if (resp_live) begin
      resp_pc_d = resp_pc_q + 32'd4;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push & ~pop) begin
      count_d = count_q + CW'(1);
    end else if (pop & ~push) begin
      count_d = count_q - CW'(1);
    end

    // Redirect: flush, restart both PCs, and mark every request still in
    // flight (minus one answered this cycle) as stale.
    if (redirect) begin
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      discard_d  = imem_rvalid ? (outst_q - CW'(1)) : outst_q;
    end
  end

  // Control state registers; if_pc keeps the last head PC once drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_VECTOR;
      resp_pc_q  <= RESET_VECTOR;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (fifo_nonempty) begin
        last_pc_q <= fifo_pc_q[rd_ptr_q];
      end
    end
  end

  // FIFO data storage; validity is tracked by the pointers and count only.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= resp_pc_q;
      fifo_ins_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer.
// An instruction-memory model answers granted requests in order; a scoreboard
// of expected {pc, word, fault} entries is filled as responses are returned
// and compared whenever decode pops. A vector table drives redirect cases.
`timescale 1ns/1ps
module tb_instruction_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_ready;
`ifdef FETCH_FAULT_EN
  logic        imem_err;
  logic        if_fault;
  logic        fault_seen;
`endif

  always #5 clk = ~clk;

  instruction_fetch_buffer #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_VECTOR(RV)
  ) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
`ifdef FETCH_FAULT_EN
    .imem_err(imem_err), .if_fault(if_fault),
`endif
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
    .if_ready(if_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        flt;
  } ent_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } redir_vec_t;

  int          errors = 0;
  int          checks = 0;

  // Memory model and scoreboard state
  logic [31:0] pend_q[$];
  logic        stale_q[$];
  ent_t        exp_q[$];
  logic [31:0] grant_log[$];
  logic        cur_valid, cur_stale, cur_err;
  logic [31:0] cur_addr;
  logic [31:0] exp_fetch;
  logic [31:0] fault_addr;
  logic        resp_en;
  logic        hold;
  logic        prev_stall;
  logic [31:0] prev_addr;
  logic [31:0] first_pop_pc;
  int          tick_no, grants, pops, first_grant, first_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: sample just after the negedge, update the model for the
  // coming posedge, then set the memory response for the next cycle.
  task automatic tick();
    logic granted, popped;
    ent_t e;
    #1;
    if (prev_stall) chk("addr_stable", imem_addr, prev_addr);
    if (redirect) chk("req_low_on_redirect", imem_req, 0);
    if (hold) chk("req_low_after_fault", imem_req, 0);
    chk("if_valid", if_valid, exp_q.size() != 0);
    if (!if_valid) begin
      chk("nop_when_empty", if_instruction, NOP);
`ifdef FETCH_FAULT_EN
      chk("fault_when_empty", if_fault, 0);
`endif
    end

    granted = imem_req & imem_gnt;
    if (granted) begin
      chk("grant_addr", imem_addr, exp_fetch);
      chk("outstanding_limit", (pend_q.size() + int'(cur_valid)) < MAXO, 1);
      chk("credit_limit", (exp_q.size() + pend_q.size() + int'(cur_valid)) < DEPTH, 1);
      if (first_grant < 0) first_grant = tick_no;
      grant_log.push_back(imem_addr);
      grants++;
    end

    popped = if_valid & if_ready;
    if (if_valid && first_valid < 0) first_valid = tick_no;
    if (popped && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("if_pc", if_pc, e.pc);
      chk("if_instruction", if_instruction, e.ins);
`ifdef FETCH_FAULT_EN
      chk("if_fault", if_fault, e.flt);
      if (e.flt && if_fault === 1'b1) fault_seen = 1'b1;
`endif
      if (pops == 0) first_pop_pc = if_pc;
      pops++;
    end

    if (granted) begin
      pend_q.push_back(imem_addr);
      stale_q.push_back(1'b0);
      exp_fetch = exp_fetch + 32'd4;
    end
    prev_stall = imem_req & ~imem_gnt & ~redirect;
    prev_addr  = imem_addr;

    if (redirect) begin
      exp_q.delete();
      foreach (stale_q[i]) stale_q[i] = 1'b1;
      exp_fetch = redirect_pc & 32'hFFFF_FFFC;
      hold = 1'b0;
    end else if (cur_valid && !cur_stale && !hold) begin
      chk("no_push_into_full", exp_q.size() < DEPTH, 1);
      e.pc  = cur_addr;
      e.ins = mem_word(cur_addr);
      e.flt = cur_err;
      exp_q.push_back(e);
      if (cur_err) hold = 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
    tick_no++;
    redirect = 1'b0;
    if (resp_en && pend_q.size() != 0) begin
      cur_valid = 1'b1;
      cur_addr  = pend_q.pop_front();
      cur_stale = stale_q.pop_front();
    end else begin
      cur_valid = 1'b0;
      cur_stale = 1'b0;
    end
    cur_err     = cur_valid && (cur_addr == fault_addr);
    imem_rvalid = cur_valid;
    imem_rdata  = cur_valid ? mem_word(cur_addr) : $urandom();
`ifdef FETCH_FAULT_EN
    imem_err    = cur_err;
`endif
  endtask

  // Reset both the DUT and the memory model, checking reset outputs.
  task automatic do_reset();
    reset       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    cur_valid   = 1'b0;
    cur_stale   = 1'b0;
    cur_err     = 1'b0;
    pend_q.delete();
    stale_q.delete();
    exp_q.delete();
    exp_fetch   = RV;
    hold        = 1'b0;
    prev_stall  = 1'b0;
`ifdef FETCH_FAULT_EN
    imem_err    = 1'b0;
`endif
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, RV);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instruction", if_instruction, NOP);
`ifdef FETCH_FAULT_EN
    chk("rst_if_fault", if_fault, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    first_grant = -1;
    first_valid = -1;
    grants  = 0;
    pops    = 0;
    tick_no = 0;
    grant_log.delete();
  endtask

  initial begin
    redir_vec_t vecs[4];
    vecs[0] = '{rpc: 32'h0000_0300, exp_addr: 32'h0000_0300};
    vecs[1] = '{rpc: 32'h0000_1002, exp_addr: 32'h0000_1000};
    vecs[2] = '{rpc: 32'h0000_0203, exp_addr: 32'h0000_0200};
    vecs[3] = '{rpc: 32'hFFFF_FFF8, exp_addr: 32'hFFFF_FFF8};

    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if_ready    = 1'b1;
    resp_en     = 1'b1;
    fault_addr  = 32'h0000_0001;
    first_pop_pc = 32'h0;
`ifdef FETCH_FAULT_EN
    imem_err    = 1'b0;
    fault_seen  = 1'b0;
`endif
    @(negedge clk);

    // Zero-wait streaming from the reset vector
    do_reset();
    repeat (12) tick();
    chk("first_valid_latency", first_valid - first_grant, 2);
    chk("stream_pops", pops, 10);
    chk("stream_first_pc", first_pop_pc, RV);

    // Decode stalled: fetch stops at DEPTH entries, then drains in order
    if_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("stall_grants", grants, DEPTH);
    chk("stall_req_low", imem_req, 0);
    chk("stall_if_valid", if_valid, 1);
    if_ready = 1'b1;
    repeat (4) tick();
    chk("drain_pops", pops, 4);
    chk("drain_first_pc", first_pop_pc, RV);

    // Redirect with two requests outstanding and unanswered
    imem_gnt = 1'b0;
    resp_en  = 1'b0;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0010;
    tick();
    imem_gnt = 1'b1;
    repeat (3) tick();
    chk("two_outstanding", grants, 2);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    resp_en = 1'b1;
    pops = 0;
    repeat (12) tick();
    chk("after_discard_first_pc", first_pop_pc, 32'h0000_0200);
    chk("after_discard_popped", pops > 0, 1);

    // Redirect table: each lands on a cycle with a response and a pop
    for (int v = 0; v < 4; v++) begin
      repeat (4) tick();
      chk("pre_redirect_resp", imem_rvalid, 1);
      chk("pre_redirect_pop", if_valid & if_ready, 1);
      redirect = 1'b1;
      redirect_pc = vecs[v].rpc;
      tick();
      grant_log.delete();
      #1;
      chk("redir_fifo_empty", if_valid, 0);
      chk("redir_req", imem_req, 1);
      chk("redir_addr", imem_addr, vecs[v].exp_addr);
    end

    // Address wrap after fetching at 0xFFFF_FFF8
    repeat (3) tick();
    chk("wrap_grants", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      chk("wrap_addr0", grant_log[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", grant_log[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", grant_log[2], 32'h0000_0000);
    end
    repeat (4) tick();

    // Back-to-back redirects: last one wins
    redirect = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0500;
    tick();
    pops = 0;
    repeat (8) tick();
    chk("b2b_first_pc", first_pop_pc, 32'h0000_0500);

    // Random stalls, latencies, backpressure and redirects
    for (int i = 0; i < 400; i++) begin
      imem_gnt = ($urandom_range(0, 3) != 0);
      resp_en  = ($urandom_range(0, 3) != 0);
      if_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect = 1'b1;
        redirect_pc = $urandom();
      end
      tick();
    end
    imem_gnt = 1'b0;
    resp_en  = 1'b1;
    if_ready = 1'b1;
    repeat (20) tick();
    chk("random_drained", if_valid, 0);

`ifdef FETCH_FAULT_EN
    // Fetch fault on 0x20 holds fetch until the trap redirect
    imem_gnt   = 1'b1;
    fault_addr = 32'h0000_0020;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0018;
    tick();
    fault_seen = 1'b0;
    repeat (10) tick();
    chk("fault_seen", fault_seen, 1);
    chk("fault_req_held", imem_req, 0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0080;
    tick();
    #1;
    chk("fault_resume_req", imem_req, 1);
    chk("fault_resume_addr", imem_addr, 32'h0000_0080);
    pops = 0;
    repeat (6) tick();
    chk("fault_resume_pc", first_pop_pc, 32'h0000_0080);
    fault_addr = 32'h0000_0001;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
